// File: rtl/jtopl_csr_q_if.sv
// Register-interface bus for jtopl_csr_q: a queued masked write port and a
// slot-addressed read port, each with its own busy/done handshake.
interface jtopl_csr_q_if #(
  parameter int SLOTW = 5
);
  logic             wr_req;
  logic [SLOTW-1:0] wr_slot;
  logic [2:0]       wr_reg;
  logic [7:0]       wr_mask;
  logic [7:0]       din;
  logic             wr_busy;
  logic             wr_done;
  logic             wr_err;

  logic             rd_req;
  logic [SLOTW-1:0] rd_slot;
  logic [2:0]       rd_reg;
  logic             rd_busy;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_err;

  modport master (
    output wr_req, wr_slot, wr_reg, wr_mask, din,
    input  wr_busy, wr_done, wr_err,
    output rd_req, rd_slot, rd_reg,
    input  rd_busy, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_req, wr_slot, wr_reg, wr_mask, din,
    output wr_busy, wr_done, wr_err,
    input  rd_req, rd_slot, rd_reg,
    output rd_busy, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/jtopl_csr_q.sv
// Operator circular shift register holding NREG bytes per slot for STAGES
// slots, with a depth-1 masked write queue and a slot-addressed readback.
module jtopl_csr_q #(
  parameter int STAGES = 18,
  parameter int NREG   = 5,
  parameter int SLOTW  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  output logic [8*NREG-1:0]   shift_out,
  output logic [SLOTW-1:0]    cur_slot,
  jtopl_csr_q_if.slave        bus
);
  localparam int W = 8 * NREG;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  // Head of the ring is ring[0]; words move towards index 0 on each cen.
  logic [W-1:0]     ring [STAGES];
  logic [W-1:0]     next_word;

  logic [0:0]       wr_state;
  logic [SLOTW-1:0] wr_slot_q;
  logic [2:0]       wr_reg_q;
  logic [7:0]       wr_mask_q;
  logic [7:0]       wr_data_q;
  logic             wr_legal;
  logic             wr_apply;

  logic [0:0]       rd_state;
  logic [SLOTW-1:0] rd_slot_q;
  logic [2:0]       rd_reg_q;
  logic             rd_legal;
  logic             rd_capture;
  logic [7:0]       rd_byte;

  assign shift_out = ring[0];

  assign wr_legal   = (32'(bus.wr_slot) < STAGES) && (32'(bus.wr_reg) < NREG);
  assign rd_legal   = (32'(bus.rd_slot) < STAGES) && (32'(bus.rd_reg) < NREG);
  assign wr_apply   = (wr_state == PEND) && cen && (cur_slot == wr_slot_q);
  assign rd_capture = (rd_state == PEND) && cen && (cur_slot == rd_slot_q);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_word = ring[0];
    if (wr_apply) begin
      for (int k = 0; k < NREG; k++) begin
        if (wr_reg_q == 3'(k)) begin
          next_word[8*k +: 8] = (ring[0][8*k +: 8] & ~wr_mask_q) |
                                (wr_data_q & wr_mask_q);
        end
      end
    end
  end

  // Readback taps next_word so a write landing in the same cycle is seen.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (rd_reg_q == 3'(k)) rd_byte = next_word[8*k +: 8];
    end
  end

  // NOTE: the ring is cleared on reset like any other register; this is a
  // flop array, not a RAM, and the operators must start from known state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage of the shift samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) ring[i] <= '0;
      cur_slot <= '0;
    end else if (cen) begin
      for (int i = 0; i < STAGES - 1; i++) ring[i] <= ring[i+1];
      ring[STAGES-1] <= next_word;
      cur_slot <= (cur_slot == SLOTW'(STAGES - 1)) ? '0 : cur_slot + 1'b1;
    end
  end

  // Write queue: illegal requests complete with an error without ever
  // occupying the queue, so wr_busy stays low for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state    <= IDLE;
      wr_slot_q   <= '0;
      wr_reg_q    <= '0;
      wr_mask_q   <= '0;
      wr_data_q   <= '0;
      bus.wr_busy <= 1'b0;
      bus.wr_done <= 1'b0;
      bus.wr_err  <= 1'b0;
    end else begin
      bus.wr_done <= 1'b0;
      bus.wr_err  <= 1'b0;
      case (wr_state)
        IDLE: begin
          if (bus.wr_req) begin
            if (wr_legal) begin
              wr_slot_q   <= bus.wr_slot;
              wr_reg_q    <= bus.wr_reg;
              wr_mask_q   <= bus.wr_mask;
              wr_data_q   <= bus.din;
              wr_state    <= PEND;
              bus.wr_busy <= 1'b1;
            end else begin
              bus.wr_done <= 1'b1;
              bus.wr_err  <= 1'b1;
            end
          end
        end
        PEND: begin
          if (wr_apply) begin
            wr_state    <= IDLE;
            bus.wr_busy <= 1'b0;
            bus.wr_done <= 1'b1;
          end
        end
        default: wr_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state     <= IDLE;
      rd_slot_q    <= '0;
      rd_reg_q     <= '0;
      bus.rd_busy  <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      case (rd_state)
        IDLE: begin
          if (bus.rd_req) begin
            if (rd_legal) begin
              rd_slot_q   <= bus.rd_slot;
              rd_reg_q    <= bus.rd_reg;
              rd_state    <= PEND;
              bus.rd_busy <= 1'b1;
            end else begin
              bus.rd_valid <= 1'b1;
              bus.rd_err   <= 1'b1;
            end
          end
        end
        PEND: begin
          if (rd_capture) begin
            rd_state     <= IDLE;
            bus.rd_busy  <= 1'b0;
            bus.rd_valid <= 1'b1;
            bus.rd_data  <= rd_byte;
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtopl_csr_q.sv
// Directed bench for jtopl_csr_q (STAGES=18, NREG=5): ring rotation, queued
// masked writes, readback, illegal requests, cen stall and mid-write reset.
module tb_jtopl_csr_q;
  localparam int STAGES = 18;
  localparam int NREG   = 5;
  localparam int SLOTW  = 5;
  localparam int W      = 8 * NREG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cen;
  logic [W-1:0]     shift_out;
  logic [SLOTW-1:0] cur_slot;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_ring [STAGES];

  jtopl_csr_q_if #(.SLOTW(SLOTW)) bus ();

  jtopl_csr_q #(.STAGES(STAGES), .NREG(NREG), .SLOTW(SLOTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .shift_out (shift_out),
    .cur_slot  (cur_slot),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    while (cur_slot != SLOTW'(s) && n < 60) begin
      tick();
      n++;
    end
    check("slot_sync", 64'(cur_slot), 64'(s));
  endtask

  task automatic wait_wr(input string tag);
    int n = 0;
    while (!bus.wr_done && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.wr_done), 64'd1);
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    while (!bus.rd_valid && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.rd_valid), 64'd1);
  endtask

  task automatic issue_wr(input int slot, input int rg, input logic [7:0] m, input logic [7:0] d);
    bus.wr_slot = SLOTW'(slot);
    bus.wr_reg  = 3'(rg);
    bus.wr_mask = m;
    bus.din     = d;
    bus.wr_req  = 1'b1;
    tick();
    bus.wr_req  = 1'b0;
  endtask

  task automatic issue_rd(input int slot, input int rg);
    bus.rd_slot = SLOTW'(slot);
    bus.rd_reg  = 3'(rg);
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
  endtask

  task automatic scan(input string tag);
    wait_slot(0);
    for (int s = 0; s < STAGES; s++) begin
      check(tag, 64'(shift_out), 64'(exp_ring[s]));
      tick();
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int n;

    rst_n = 1'b0;
    cen   = 1'b0;
    bus.wr_req = 1'b0; bus.wr_slot = '0; bus.wr_reg = '0; bus.wr_mask = '0; bus.din = '0;
    bus.rd_req = 1'b0; bus.rd_slot = '0; bus.rd_reg = '0;
    for (int s = 0; s < STAGES; s++) exp_ring[s] = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_cur_slot", 64'(cur_slot), 64'd0);
    check("rst_shift_out", 64'(shift_out), 64'd0);
    check("rst_status",
          64'({bus.wr_busy, bus.wr_done, bus.wr_err, bus.rd_busy, bus.rd_valid, bus.rd_err}),
          64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);

    // Free-running rotation 0..17,0 with an all-zero ring.
    cen = 1'b1;
    tick();
    for (int i = 0; i <= STAGES; i++) begin
      check("rot_slot", 64'(cur_slot), 64'((i + 1) % STAGES));
      check("rot_word", 64'(shift_out), 64'd0);
      tick();
    end

    // Full-byte write to slot 5 reg 2 accepted while slot 9 is at the head.
    wait_slot(9);
    issue_wr(5, 2, 8'hFF, 8'hA5);
    check("wr_busy_rise", 64'(bus.wr_busy), 64'd1);
    busy_cnt = 0;
    n = 0;
    while (!bus.wr_done && n < 60) begin
      if (bus.wr_busy) busy_cnt++;
      tick();
      n++;
    end
    check("wr_done_seen", 64'(bus.wr_done), 64'd1);
    check("wr_busy_ticks", 64'(busy_cnt), 64'd14);
    check("wr_busy_fall", 64'(bus.wr_busy), 64'd0);
    check("wr_err_clean", 64'(bus.wr_err), 64'd0);
    tick();
    check("wr_done_pulse", 64'(bus.wr_done), 64'd0);
    exp_ring[5] = 40'h00_00_A5_00_00;
    scan("ring_after_full");

    // Partial nibble write: A5&F0 | 3C&0F = AC, then read it back.
    issue_wr(5, 2, 8'h0F, 8'h3C);
    wait_wr("wr2_done");
    check("wr2_err", 64'(bus.wr_err), 64'd0);
    exp_ring[5] = 40'h00_00_AC_00_00;
    issue_rd(5, 2);
    check("rd_busy_rise", 64'(bus.rd_busy), 64'd1);
    wait_rd("rd_valid_seen");
    check("rd_data_ac", 64'(bus.rd_data), 64'hAC);
    check("rd_err_clean", 64'(bus.rd_err), 64'd0);
    check("rd_busy_fall", 64'(bus.rd_busy), 64'd0);
    tick();
    check("rd_valid_pulse", 64'(bus.rd_valid), 64'd0);
    check("rd_data_hold", 64'(bus.rd_data), 64'hAC);

    // Same-cycle write and read on slot 7 reg 0: read sees the new byte.
    bus.wr_slot = 5'd7; bus.wr_reg = 3'd0; bus.wr_mask = 8'hFF; bus.din = 8'h11;
    bus.rd_slot = 5'd7; bus.rd_reg = 3'd0;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    n = 0;
    while (!(bus.wr_done || bus.rd_valid) && n < 60) begin
      tick();
      n++;
    end
    check("both_wr_done", 64'(bus.wr_done), 64'd1);
    check("both_rd_valid", 64'(bus.rd_valid), 64'd1);
    check("both_rd_data", 64'(bus.rd_data), 64'h11);
    exp_ring[7] = 40'h00_00_00_00_11;

    // Illegal write slot 20 and illegal read reg 6.
    tick();
    issue_wr(20, 0, 8'hFF, 8'h5A);
    check("ill_wr_done", 64'(bus.wr_done), 64'd1);
    check("ill_wr_err", 64'(bus.wr_err), 64'd1);
    check("ill_wr_busy", 64'(bus.wr_busy), 64'd0);
    issue_rd(3, 6);
    check("ill_rd_valid", 64'(bus.rd_valid), 64'd1);
    check("ill_rd_err", 64'(bus.rd_err), 64'd1);
    check("ill_rd_data", 64'(bus.rd_data), 64'h11);
    check("ill_rd_busy", 64'(bus.rd_busy), 64'd0);
    scan("ring_after_illegal");

    // Stall: cen low for 50 cycles with a write pending.
    wait_slot(3);
    cen = 1'b0;
    issue_wr(10, 1, 8'hFF, 8'h77);
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.wr_done) done_cnt++;
      tick();
    end
    check("stall_busy", 64'(bus.wr_busy), 64'd1);
    check("stall_slot", 64'(cur_slot), 64'd3);
    check("stall_word", 64'(shift_out), 64'(exp_ring[3]));
    check("stall_no_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset while the write is pending.
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.wr_busy), 64'd0);
    check("arst_slot", 64'(cur_slot), 64'd0);
    check("arst_word", 64'(shift_out), 64'd0);
    tick();
    rst_n = 1'b1;
    cen   = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wr_done || bus.wr_busy) done_cnt++;
      tick();
    end
    check("arst_no_done", 64'(done_cnt), 64'd0);
    for (int s = 0; s < STAGES; s++) exp_ring[s] = '0;
    scan("ring_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtopl_csr_q.md
Name: jtopl_csr_q

Overview:
- Parametrised successor to the operator circular shift register (CSR) for JTOPL-family cores.
- Holds NREG bytes of per-slot register state for STAGES slots, rotating one slot per cen tick.
- Adds a queued, bit-masked write port and a slot-addressed readback port, so CPU register writes no longer have to line up with the slot currently at the head.
- Sits between the register-interface decoder and the operator pipeline (PG/EG/OP), which consume shift_out.

Parameters:
- STAGES, 18, number of slots in the ring (2..32).
- NREG, 5, register bytes per slot (1..8). Ring word width W = 8*NREG.
- SLOTW, 5, slot index width. Requires 2^SLOTW >= STAGES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  clock enable; the ring advances only on cycles with cen=1.
- shift_out  out  8*NREG  register word of the slot at the head (cur_slot); byte k = bits [8k+7:8k].
- cur_slot  out  SLOTW  index of the slot currently at shift_out.
- wr_req  in  1  write request; sampled on any clk cycle.
- wr_slot  in  SLOTW  target slot.
- wr_reg  in  3  target byte index.
- wr_mask  in  8  bit-enable mask.
- din  in  8  write data.
- wr_busy  out  1  a write is pending.
- wr_done  out  1  one-cycle pulse when a write completes.
- wr_err  out  1  valid with wr_done; the write was discarded.
- rd_req  in  1  read request.
- rd_slot  in  SLOTW  slot to read.
- rd_reg  in  3  byte to read.
- rd_busy  out  1  a read is pending.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  8  read result, held until the next rd_valid.
- rd_err  out  1  valid with rd_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ring words = 0 and cur_slot = 0.
  - wr_busy, wr_done, wr_err, rd_busy, rd_valid, rd_err = 0; rd_data = 0.
  - Any pending write or read is dropped with no done/valid pulse.
- Ring:
  - STAGES x W shift register. On cen, the word at the head re-enters the tail as next_word.
  - cur_slot increments and wraps from STAGES-1 to 0.
  - After reset, slot s is at the head when cur_slot = s.
- next_word: equals shift_out, except when a write is applied this cycle.
  - Applied write: byte wr_reg' = (old & ~mask') | (din' & mask'), where ' denotes the latched value.
- Write FSM, states IDLE and PEND:
  - IDLE: wr_req=1 latches slot/reg/mask/data and enters PEND; wr_busy=1 from the next cycle.
  - wr_req while PEND is ignored; no queueing beyond depth 1, so the requester retries.
  - Illegal request (wr_slot >= STAGES or wr_reg >= NREG): no ring change; next cycle wr_done=1, wr_err=1; FSM returns to IDLE. wr_busy is never raised.
  - PEND: on the first cycle with cen=1 and cur_slot = slot', the masked write is applied to next_word. On the following cycle wr_done=1, wr_busy=0, and the FSM is in IDLE.
  - Worst-case latency is STAGES cen ticks plus 1 clk. If the target slot is at the head on the acceptance cycle, the write is not applied until that slot's next pass, because the request is latched first.
  - wr_mask = 0 still completes normally; the ring word is unchanged.
- Read FSM, same structure as the write FSM:
  - Capture occurs on cen with cur_slot = slot'. rd_data = byte rd_reg' of next_word, so a write applied in the same cycle is visible.
  - rd_valid pulses on the next cycle and rd_busy drops.
  - Illegal read: rd_valid=1, rd_err=1, rd_data unchanged.
- Concurrency:
  - Write and read FSMs are independent and may complete on the same cycle.
- cen=0:
  - Ring and cur_slot hold; pending operations wait.
  - Accept and illegal-completion paths still run on clk.
- Timing:
  - Outputs shift_out and cur_slot are registered with no combinational path from inputs.
  - rd_data, the done/valid pulses and the err flags are registered.

Test Plan:
- Reset, then cen=1 continuously: cur_slot goes 0..17,0; shift_out=0; all status outputs 0.
- Write slot 5, reg 2, mask FF, din A5 while cur_slot=9: wr_busy for 14 cen ticks, then wr_done. Byte 2 of shift_out = A5 whenever cur_slot=5, and 00 in all other slots.
- Partial write on the same slot, mask 0F, din 3C: byte becomes A5&F0 | 0C = AC. A read of slot 5, reg 2 returns rd_data=AC, rd_err=0.
- Read and write to slot 7, reg 0 issued on the same cycle with din 11: both complete on the same cycle; rd_data=11.
- wr_slot=20 (with STAGES=18): wr_done=wr_err=1 one cycle later, ring unchanged. Read with rd_reg=6 (with NREG=5): rd_err=1.
- Assert rst_n low mid-PEND: wr_busy drops immediately, no wr_done pulse, ring cleared. Hold cen=0 for 50 cycles with a write pending: wr_busy stays 1 and cur_slot is frozen.
